// File: rtl/capture_config_sequencer_pkg.sv
// Shared types for the capture path: video configuration record, its
// power-on value and the sequencer state encoding.
package capture_config_sequencer_pkg;

    // Configuration handed to video2ram
    typedef struct packed {
        logic [7:0]  buffer_size;
        logic [11:0] x_start;
        logic [11:0] y_start;
        logic        interlaced;
    } DCVideoConfig;

    localparam DCVideoConfig DC_VIDEO_CONFIG_DEFAULT = '{
        buffer_size: 8'd32,
        x_start:     12'd0,
        y_start:     12'd0,
        interlaced:  1'b0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_APPLY,
        ST_SETTLE
    } cfg_seq_state_t;

    // Settle counter holds 1..15 frames
    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/frame_edge_detect.sv
// Registered frame-start pulse: one cycle after the raster first reaches
// (0,0). A raster parked at the origin still yields only one pulse.
module frame_edge_detect (
    input  logic        clock,
    input  logic        nreset,
    input  logic [11:0] counterX,
    input  logic [11:0] counterY,
    output logic        fs
);

    logic at_origin;
    logic at_origin_prev;

    assign at_origin = (counterX == 12'd0) && (counterY == 12'd0);

    // Remember last cycle's origin flag and emit the rising edge
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            at_origin_prev <= 1'b0;
            fs             <= 1'b0;
        end else begin
            at_origin_prev <= at_origin;
            fs             <= at_origin && !at_origin_prev;
        end
    end

endmodule

// File: rtl/capture_config_sequencer.sv
// Capture configuration sequencer: buffers requested configurations in a
// shadow register, applies them at frame start and keeps video2ram gated
// for a settle period after every apply or mode change.
// Optional frame watchdog: define CAPTURE_WATCHDOG_EN.
module capture_config_sequencer
    import capture_config_sequencer_pkg::*;
#(
    parameter int SETTLE_FRAMES = 2,
    parameter int WDOG_FRAMES   = 4
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic [11:0]  counterX,
    input  logic [11:0]  counterY,
    input  logic         line_doubler,
    input  logic         is_pal,
    input  logic         starttrigger,
    input  DCVideoConfig cfg_in,
    input  logic         cfg_req,
    output logic         cfg_ack,
    output DCVideoConfig cfg_active,
    output logic         line_doubler_out,
    output logic         is_pal_out,
    output logic         capture_enable,
    output logic         resync,
    output logic         wdog_fired
);

    // Out-of-range settle lengths are clamped into the counter's range
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = 4'((SETTLE_FRAMES < 1) ? 1 :
                                                         (SETTLE_FRAMES > 15) ? 15 : SETTLE_FRAMES);

    cfg_seq_state_t            state_reg, state_next;
    logic                      fs;
    logic                      mc;
    logic                      accept;
    logic                      settle_done;
    logic                      wdog_trip;
    logic                      line_doubler_reg, is_pal_reg;
    DCVideoConfig              shadow_reg;
    logic [SETTLE_CNT_W-1:0]   settle_cnt_reg;
    logic                      pend_reg;       // request taken during SETTLE
    logic                      apply_due_reg;  // apply postponed by a shadow write
    logic                      cfg_ack_next, capture_enable_next, resync_next;

    frame_edge_detect u_fs (
        .clock    (clock),
        .nreset   (nreset),
        .counterX (counterX),
        .counterY (counterY),
        .fs       (fs)
    );

    assign mc          = (line_doubler_reg != line_doubler_out) || (is_pal_reg != is_pal_out);
    // A request is never taken while its ack is visible or during the APPLY cycle
    assign accept      = cfg_req && !cfg_ack && (state_reg != ST_APPLY);
    assign settle_done = fs && !mc && (settle_cnt_reg <= 4'd1);

    // State register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state_reg <= ST_SETTLE;
        else         state_reg <= state_next;
    end

    // Next-state decision
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept)         state_next = ST_PENDING;
                else if (mc)        state_next = ST_APPLY;
                else if (wdog_trip) state_next = ST_SETTLE;
            end
            ST_PENDING: begin
                // A shadow write wins over apply; the apply follows one cycle later
                if (accept)                           state_next = ST_PENDING;
                else if (fs || mc || apply_due_reg)   state_next = ST_APPLY;
            end
            ST_APPLY:  state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_done) state_next = (pend_reg || accept) ? ST_PENDING : ST_IDLE;
            end
            default:   state_next = ST_SETTLE;
        endcase
    end

    // Next values of the registered handshake and gating outputs
    always_comb begin
        cfg_ack_next        = accept;
        capture_enable_next = (state_next != ST_SETTLE);
        resync_next         = (state_reg == ST_SETTLE) && (state_next != ST_SETTLE);
    end

    // Output registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cfg_ack        <= 1'b0;
            capture_enable <= 1'b0;
            resync         <= 1'b0;
        end else begin
            cfg_ack        <= cfg_ack_next;
            capture_enable <= capture_enable_next;
            resync         <= resync_next;
        end
    end

    // Shadow, active configuration, mode bits and settle counter
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            line_doubler_reg <= 1'b0;
            is_pal_reg       <= 1'b0;
            shadow_reg       <= DC_VIDEO_CONFIG_DEFAULT;
            cfg_active       <= DC_VIDEO_CONFIG_DEFAULT;
            line_doubler_out <= 1'b0;
            is_pal_out       <= 1'b0;
            settle_cnt_reg   <= SETTLE_LOAD;
            pend_reg         <= 1'b0;
            apply_due_reg    <= 1'b0;
        end else begin
            line_doubler_reg <= line_doubler;
            is_pal_reg       <= is_pal;
            if (accept)
                shadow_reg <= cfg_in;
            else if (state_reg == ST_IDLE && mc)
                shadow_reg <= cfg_active;   // mode-only change reapplies current config
            apply_due_reg <= (state_reg == ST_PENDING) && accept && (fs || mc);
            case (state_reg)
                ST_APPLY: begin
                    cfg_active       <= shadow_reg;
                    line_doubler_out <= line_doubler_reg;
                    is_pal_out       <= is_pal_reg;
                    settle_cnt_reg   <= SETTLE_LOAD;
                    pend_reg         <= 1'b0;
                end
                ST_SETTLE: begin
                    if (mc) begin
                        line_doubler_out <= line_doubler_reg;
                        is_pal_out       <= is_pal_reg;
                        settle_cnt_reg   <= SETTLE_LOAD;
                    end else if (fs && settle_cnt_reg != '0) begin
                        settle_cnt_reg <= settle_cnt_reg - 4'd1;
                    end
                    if (accept) pend_reg <= 1'b1;
                end
                ST_IDLE: begin
                    if (state_next == ST_SETTLE) settle_cnt_reg <= SETTLE_LOAD;
                end
                default: ;
            endcase
        end
    end

`ifdef CAPTURE_WATCHDOG_EN
    localparam int              WDOG_LIMIT = (WDOG_FRAMES < 1) ? 1 : (WDOG_FRAMES > 255) ? 255 : WDOG_FRAMES;
    localparam logic [7:0]      WDOG_LAST  = 8'(WDOG_LIMIT - 1);

    logic [7:0] wdog_cnt_reg;
    logic       seen_trig_reg;   // starttrigger since the previous fs

    assign wdog_trip = (state_reg == ST_IDLE) && fs && !seen_trig_reg && !starttrigger &&
                       (wdog_cnt_reg >= WDOG_LAST);

    // Count silent frames while idle; any trigger restarts the count
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wdog_cnt_reg  <= 8'd0;
            seen_trig_reg <= 1'b0;
            wdog_fired    <= 1'b0;
        end else begin
            wdog_fired <= wdog_trip && (state_next == ST_SETTLE);
            if (state_reg != ST_IDLE) begin
                wdog_cnt_reg  <= 8'd0;
                seen_trig_reg <= 1'b0;
            end else begin
                if (starttrigger)
                    wdog_cnt_reg <= 8'd0;
                else if (fs && !seen_trig_reg && wdog_cnt_reg != 8'hFF)
                    wdog_cnt_reg <= wdog_cnt_reg + 8'd1;
                if (fs)
                    seen_trig_reg <= starttrigger;
                else if (starttrigger)
                    seen_trig_reg <= 1'b1;
            end
        end
    end
`else
    // Watchdog compiled out: trigger input and limit are intentionally unconsumed
    logic wdog_unused;
    assign wdog_unused = starttrigger ^ WDOG_FRAMES[0];
    assign wdog_trip   = 1'b0;
    assign wdog_fired  = 1'b0;
`endif

endmodule

// File: tb/tb_capture_config_sequencer.sv
// Self-checking bench for capture_config_sequencer on a small free-running
// raster; applied configurations are tracked by a scoreboard queue.
module tb_capture_config_sequencer;
    import capture_config_sequencer_pkg::*;

    localparam int H      = 14;
    localparam int V      = 110;
    localparam int FRAME  = H * V;
    localparam int SETTLE = 2;
    localparam int WDOG   = 4;

    logic         clock = 1'b0;
    logic         nreset;
    logic [11:0]  counterX, counterY;
    logic         line_doubler, is_pal, starttrigger;
    DCVideoConfig cfg_in;
    logic         cfg_req;
    logic         cfg_ack;
    DCVideoConfig cfg_active;
    logic         line_doubler_out, is_pal_out, capture_enable, resync, wdog_fired;

    int           checks = 0;
    int           errors = 0;
    bit           trig_en = 1'b1;
    DCVideoConfig sb_q[$];
    DCVideoConfig cur_cfg;
    int           resync_seen = 0;
    int           wdog_seen   = 0;
    int           exp_resync  = 0;

    capture_config_sequencer #(
        .SETTLE_FRAMES (SETTLE),
        .WDOG_FRAMES   (WDOG)
    ) dut (
        .clock            (clock),
        .nreset           (nreset),
        .counterX         (counterX),
        .counterY         (counterY),
        .line_doubler     (line_doubler),
        .is_pal           (is_pal),
        .starttrigger     (starttrigger),
        .cfg_in           (cfg_in),
        .cfg_req          (cfg_req),
        .cfg_ack          (cfg_ack),
        .cfg_active       (cfg_active),
        .line_doubler_out (line_doubler_out),
        .is_pal_out       (is_pal_out),
        .capture_enable   (capture_enable),
        .resync           (resync),
        .wdog_fired       (wdog_fired)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_origin();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (counterX == 12'd0 && counterY == 12'd0) found = 1'b1;
        end
        if (!found) check_eq("origin_timeout", 64'(found), 64'd1);
    endtask

    task automatic wait_line(input int y);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (counterX == 12'd0 && counterY == 12'(y)) found = 1'b1;
        end
        if (!found) check_eq("line_timeout", 64'(found), 64'd1);
    endtask

    function automatic DCVideoConfig mk_cfg(input logic [7:0] bs);
        DCVideoConfig c;
        c.buffer_size = bs;
        c.x_start     = {4'd0, bs};
        c.y_start     = {4'd1, bs};
        c.interlaced  = bs[3];
        return c;
    endfunction

    // Last request wins while nothing has been applied yet
    task automatic sb_expect(input DCVideoConfig v);
        if (sb_q.size() > 0) sb_q[sb_q.size() - 1] = v;
        else                 sb_q.push_back(v);
    endtask

    task automatic drive_req(input DCVideoConfig v);
        @(negedge clock);
        cfg_in  = v;
        cfg_req = 1'b1;
        sb_expect(v);
        tick();
        check_eq("ack_pulse", 64'(cfg_ack), 64'd1);
        @(negedge clock);
        cfg_req = 1'b0;
        tick();
        check_eq("ack_single", 64'(cfg_ack), 64'd0);
    endtask

    task automatic check_settle(input int n);
        for (int i = 0; i < n; i++) begin
            wait_origin();
            check_eq("settle_ce_low", 64'(capture_enable), 64'd0);
            check_eq("settle_no_resync", 64'(resync), 64'd0);
        end
        tick();
        check_eq("settle_ce_high", 64'(capture_enable), 64'd1);
        check_eq("settle_resync", 64'(resync), 64'd1);
        exp_resync++;
        tick();
        check_eq("resync_single", 64'(resync), 64'd0);
    endtask

    // Raster and start-trigger generator
    initial begin
        counterX     = 12'd0;
        counterY     = 12'd50;
        starttrigger = 1'b0;
        forever begin
            @(negedge clock);
            if (counterX == 12'(H - 1)) begin
                counterX = 12'd0;
                counterY = (counterY == 12'(V - 1)) ? 12'd0 : counterY + 12'd1;
            end else begin
                counterX = counterX + 12'd1;
            end
            starttrigger = trig_en && counterY == 12'd5 && counterX == 12'd3;
        end
    end

    // Scoreboard monitor: every cfg_active change must match the next expected config
    initial begin
        DCVideoConfig prev;
        DCVideoConfig exp_v;
        prev = DC_VIDEO_CONFIG_DEFAULT;
        forever begin
            tick();
            if (!nreset) begin
                prev = DC_VIDEO_CONFIG_DEFAULT;
            end else begin
                if (resync)     resync_seen++;
                if (wdog_fired) wdog_seen++;
                if (cfg_active != prev) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_unexpected_change", 64'(cfg_active), 64'(prev));
                    end else begin
                        exp_v = sb_q.pop_front();
                        check_eq("sb_cfg_active", 64'(cfg_active), 64'(exp_v));
                    end
                    check_eq("ce_low_on_apply", 64'(capture_enable), 64'd0);
                    prev = cfg_active;
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        nreset       = 1'b0;
        cfg_req      = 1'b0;
        cfg_in       = DC_VIDEO_CONFIG_DEFAULT;
        line_doubler = 1'b0;
        is_pal       = 1'b0;
        cur_cfg      = DC_VIDEO_CONFIG_DEFAULT;

        // Reset values
        repeat (3) tick();
        check_eq("rst_ce", 64'(capture_enable), 64'd0);
        check_eq("rst_ack", 64'(cfg_ack), 64'd0);
        check_eq("rst_resync", 64'(resync), 64'd0);
        check_eq("rst_wdog", 64'(wdog_fired), 64'd0);
        check_eq("rst_ld", 64'(line_doubler_out), 64'd0);
        check_eq("rst_pal", 64'(is_pal_out), 64'd0);
        check_eq("rst_cfg", 64'(cfg_active), 64'(DC_VIDEO_CONFIG_DEFAULT));
        @(negedge clock);
        nreset = 1'b1;

        // Reset release: gated until the 2nd frame start
        tick();
        check_eq("t1_ce_after_release", 64'(capture_enable), 64'd0);
        check_settle(SETTLE);
        check_eq("t1_cfg_default", 64'(cfg_active), 64'(DC_VIDEO_CONFIG_DEFAULT));

        // Single request at line 100
        wait_line(100);
        drive_req(mk_cfg(8'd16));
        check_eq("t2_cfg_held", 64'(cfg_active), 64'(cur_cfg));
        wait_origin();
        tick();
        check_eq("t2_cfg_fs1", 64'(cfg_active), 64'(cur_cfg));
        check_eq("t2_ce_fs1", 64'(capture_enable), 64'd1);
        tick();
        cur_cfg = mk_cfg(8'd16);
        check_eq("t2_cfg_fs2", 64'(cfg_active), 64'(cur_cfg));
        check_eq("t2_ce_fs2", 64'(capture_enable), 64'd0);
        check_settle(SETTLE);

        // Two requests in one frame: only the last is applied
        wait_line(20);
        drive_req(mk_cfg(8'd8));
        wait_line(40);
        drive_req(mk_cfg(8'd24));
        wait_origin();
        tick();
        tick();
        cur_cfg = mk_cfg(8'd24);
        check_eq("t3_cfg_last", 64'(cfg_active), 64'(cur_cfg));
        check_settle(SETTLE);

        // is_pal change in IDLE, then again during SETTLE
        wait_line(50);
        @(negedge clock);
        is_pal = 1'b1;
        tick();
        check_eq("t4_pal_c0", 64'(is_pal_out), 64'd0);
        tick();
        check_eq("t4_pal_c1", 64'(is_pal_out), 64'd0);
        check_eq("t4_ce_c1", 64'(capture_enable), 64'd1);
        tick();
        check_eq("t4_pal_c2", 64'(is_pal_out), 64'd1);
        check_eq("t4_ce_c2", 64'(capture_enable), 64'd0);
        check_eq("t4_ld_kept", 64'(line_doubler_out), 64'd0);
        wait_origin();
        check_eq("t4_ce_mid", 64'(capture_enable), 64'd0);
        wait_line(50);
        @(negedge clock);
        is_pal = 1'b0;
        tick();
        check_eq("t4_pal_back_c0", 64'(is_pal_out), 64'd1);
        tick();
        check_eq("t4_pal_back_c1", 64'(is_pal_out), 64'd0);
        check_eq("t4_ce_back", 64'(capture_enable), 64'd0);
        check_settle(SETTLE);
        check_eq("t4_cfg_same", 64'(cfg_active), 64'(cur_cfg));

        // Request in the exact fs cycle while PENDING
        wait_line(30);
        drive_req(mk_cfg(8'd40));
        wait_origin();
        drive_req(mk_cfg(8'd56));
        check_eq("t5_apply_deferred", 64'(cfg_active), 64'(cur_cfg));
        tick();
        cur_cfg = mk_cfg(8'd56);
        check_eq("t5_cfg_latest", 64'(cfg_active), 64'(cur_cfg));
        check_eq("t5_ce_low", 64'(capture_enable), 64'd0);
        check_settle(SETTLE);

        // Watchdog with starttrigger held low
        trig_en = 1'b0;
`ifdef CAPTURE_WATCHDOG_EN
        for (int i = 1; i < WDOG; i++) begin
            wait_origin();
            tick();
            check_eq("t6_wdog_quiet", 64'(wdog_fired), 64'd0);
            check_eq("t6_ce_on", 64'(capture_enable), 64'd1);
        end
        wait_origin();
        tick();
        check_eq("t6_wdog_fire", 64'(wdog_fired), 64'd1);
        check_eq("t6_ce_off", 64'(capture_enable), 64'd0);
        check_eq("t6_cfg_kept", 64'(cfg_active), 64'(cur_cfg));
        tick();
        check_eq("t6_wdog_single", 64'(wdog_fired), 64'd0);
        check_settle(SETTLE);
        check_eq("t6_wdog_total", 64'(wdog_seen), 64'd1);
`else
        for (int i = 0; i < 10; i++) begin
            wait_origin();
            tick();
            check_eq("t6_wdog_off", 64'(wdog_fired), 64'd0);
            check_eq("t6_ce_on", 64'(capture_enable), 64'd1);
        end
        check_eq("t6_wdog_total", 64'(wdog_seen), 64'd0);
`endif

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        check_eq("resync_total", 64'(resync_seen), 64'(exp_resync));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
